// File: rtl/zjh_cc_pkg.sv
// Shared types and constants for the complement-to-true-form serial converter.
package zjh_cc_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   // Counter must index WIDTH-1 magnitude bits; keep at least one bit so WIDTH=2 elaborates.
   function automatic int cnt_width(input int width);
      return (width - 1 > 1) ? $clog2(width - 1) : 1;
   endfunction

endpackage

// File: rtl/zjh_cc_bitcell.sv
// Serial two's-complement cell: copies bits up to and including the first 1, inverts the rest.
module zjh_cc_bitcell (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   input  logic bit_i,
   output logic out_bit_o,
   output logic found_o
);

   logic found_q;
   logic found_d;

   always_comb begin
      // NOTE: default assignment first so every path drives found_d and no latch is inferred.
      found_d = found_q;
      if (clr_i) begin
         found_d = 1'b0;
      end else if (en_i) begin
         found_d = found_q | bit_i;
      end
   end

   // NOTE: non-blocking assignment keeps the register update race-free against other flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         found_q <= 1'b0;
      end else begin
         found_q <= found_d;
      end
   end

   assign out_bit_o = found_q ? ~bit_i : bit_i;
   assign found_o   = found_q;

endmodule

// File: rtl/zjh_cc_tf_serial.sv
// Bit-serial two's-complement to sign-magnitude converter with valid/ready handshakes.
module zjh_cc_tf_serial
   import zjh_cc_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] DataIn,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] DataOut,
   output logic             OVF,
   output logic             BUSY
);

   localparam int            MW       = WIDTH - 1;
   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 2);

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [MW-1:0]    src_q;
   logic [MW-1:0]    res_q;
   logic [WIDTH-1:0] dout_q;
   logic             ovf_q;

   logic             accept;
   logic             shift_en;
   logic             out_bit;
   logic             found_one;
   logic [MW:0]      res_ext;
   logic [MW-1:0]    res_d;

   assign accept   = (state_q == ST_IDLE) && IN_VALID;
   assign shift_en = (state_q == ST_SHIFT);

   zjh_cc_bitcell u_cell (
      .clk       (CLK),
      .rst_n     (RESET_N),
      .clr_i     (accept),
      .en_i      (shift_en),
      .bit_i     (src_q[0]),
      .out_bit_o (out_bit),
      .found_o   (found_one)
   );

   // Converted bits enter from the MSB side so the LSB-first stream lands in order.
   assign res_ext = {out_bit, res_q};
   assign res_d   = res_ext[MW:1];

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         src_q   <= '0;
         res_q   <= '0;
         dout_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (IN_VALID) begin
                  if (!DataIn[WIDTH-1]) begin
                     dout_q  <= DataIn;
                     ovf_q   <= 1'b0;
                     state_q <= ST_DONE;
                  end else begin
                     src_q   <= DataIn[MW-1:0];
                     res_q   <= '0;
                     cnt_q   <= '0;
                     state_q <= ST_SHIFT;
                  end
               end
            end
            ST_SHIFT: begin
               src_q <= src_q >> 1;
               res_q <= res_d;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST_CNT) begin
                  dout_q  <= {1'b1, res_d};
                  // No 1 anywhere in the magnitude means the input was the most negative value.
                  ovf_q   <= ~(found_one | src_q[0]);
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (OUT_READY) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign IN_READY  = (state_q == ST_IDLE);
   assign OUT_VALID = (state_q == ST_DONE);
   assign BUSY      = (state_q != ST_IDLE);
   assign DataOut   = dout_q;
   assign OVF       = ovf_q;

endmodule

// File: tb/tb_zjh_cc_tf_serial.sv
// Self-checking bench: vector table and hand sequences feed a scoreboard checked on output handshakes.
module tb_zjh_cc_tf_serial;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] din;
      logic [W-1:0] dout;
      logic         ovf;
   } vec_t;

   typedef struct {
      logic [W-1:0] dout;
      logic         ovf;
   } exp_t;

   logic         CLK;
   logic         RESET_N;
   logic         IN_VALID;
   logic         IN_READY;
   logic [W-1:0] DataIn;
   logic         OUT_VALID;
   logic         OUT_READY;
   logic [W-1:0] DataOut;
   logic         OVF;
   logic         BUSY;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   zjh_cc_tf_serial #(.WIDTH(W)) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .DataIn    (DataIn),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .DataOut   (DataOut),
      .OVF       (OVF),
      .BUSY      (BUSY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got time %0t, want < 100000", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference conversion via arithmetic negation, independent of the serial algorithm.
   function automatic exp_t model(input logic [W-1:0] x);
      exp_t         e;
      logic [W-1:0] n;
      n = ~x + 8'd1;
      if (!x[W-1]) begin
         e.dout = x;
         e.ovf  = 1'b0;
      end else if (x == 8'h80) begin
         e.dout = 8'h80;
         e.ovf  = 1'b1;
      end else begin
         e.dout = {1'b1, n[W-2:0]};
         e.ovf  = 1'b0;
      end
      return e;
   endfunction

   always @(negedge CLK) begin
      if (RESET_N && OUT_VALID && OUT_READY) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got DataOut=0x%0h with empty scoreboard, want no output", DataOut);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("dataout", 32'(DataOut), 32'(e.dout));
            check("ovf", 32'(OVF), 32'(e.ovf));
         end
      end
   end

   // Drives a word until accepted; returns one cycle after the accept edge (+1).
   task automatic send(input logic [W-1:0] d, input logic [W-1:0] exp_d, input logic exp_o,
                       input bit track, input bit hold);
      int t = 0;
      DataIn   = d;
      IN_VALID = 1'b1;
      while (!IN_READY && t < 100) begin
         @(posedge CLK); #1;
         t++;
      end
      if (!IN_READY) begin
         n_cmp++;
         n_err++;
         $display("FAIL accept_timeout: IN_READY got 0 for word 0x%0h, want 1 within 100 cycles", d);
         IN_VALID = 1'b0;
         return;
      end
      if (track) sb.push_back('{dout: exp_d, ovf: exp_o});
      @(posedge CLK); #1;
      if (!hold) IN_VALID = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((sb.size() != 0 || !IN_READY) && t < 200) begin
         @(posedge CLK); #1;
         t++;
      end
      if (sb.size() != 0 || !IN_READY) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: got %0d pending results, want 0", sb.size());
      end
   endtask

   initial begin
      vec_t vecs[12];
      exp_t e;
      logic [W-1:0] x;
      int t;

      vecs = '{
         '{din: 8'h05, dout: 8'h05, ovf: 1'b0},
         '{din: 8'hFB, dout: 8'h85, ovf: 1'b0},
         '{din: 8'hFF, dout: 8'h81, ovf: 1'b0},
         '{din: 8'h80, dout: 8'h80, ovf: 1'b1},
         '{din: 8'h81, dout: 8'hFF, ovf: 1'b0},
         '{din: 8'h00, dout: 8'h00, ovf: 1'b0},
         '{din: 8'h7F, dout: 8'h7F, ovf: 1'b0},
         '{din: 8'hC0, dout: 8'hC0, ovf: 1'b0},
         '{din: 8'hF0, dout: 8'h90, ovf: 1'b0},
         '{din: 8'h01, dout: 8'h01, ovf: 1'b0},
         '{din: 8'hFE, dout: 8'h82, ovf: 1'b0},
         '{din: 8'h40, dout: 8'h40, ovf: 1'b0}
      };

      RESET_N   = 1'b0;
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      DataIn    = '0;
      #12;
      check("rst_dataout", 32'(DataOut), 32'h00);
      check("rst_ovf", 32'(OVF), 32'h0);
      check("rst_out_valid", 32'(OUT_VALID), 32'h0);
      check("rst_busy", 32'(BUSY), 32'h0);
      @(negedge CLK);
      RESET_N = 1'b1;
      @(posedge CLK); #1;
      check("rst_in_ready", 32'(IN_READY), 32'h1);

      // Positive word: one-edge latency, ready again right after the handshake.
      send(8'h05, 8'h05, 1'b0, 1'b1, 1'b0);
      check("pos_latency_valid", 32'(OUT_VALID), 32'h1);
      @(posedge CLK); #1;
      check("ready_after_hs", 32'(IN_READY), 32'h1);

      // Negative word: seven busy shift cycles, then valid.
      send(8'hFB, 8'h85, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         check("neg_busy", 32'(BUSY), 32'h1);
         check("neg_not_valid", 32'(OUT_VALID), 32'h0);
         @(posedge CLK); #1;
      end
      check("neg_latency_valid", 32'(OUT_VALID), 32'h1);
      wait_drain();

      for (int i = 0; i < 12; i++) begin
         send(vecs[i].din, vecs[i].dout, vecs[i].ovf, 1'b1, 1'b0);
      end
      wait_drain();

      // Backpressure in DONE with a competing input that must be ignored.
      OUT_READY = 1'b0;
      send(8'h81, 8'hFF, 1'b0, 1'b1, 1'b0);
      t = 0;
      while (!OUT_VALID && t < 20) begin
         @(posedge CLK); #1;
         t++;
      end
      for (int i = 0; i < 5; i++) begin
         check("bp_out_valid", 32'(OUT_VALID), 32'h1);
         check("bp_dataout", 32'(DataOut), 32'hFF);
         check("bp_in_ready", 32'(IN_READY), 32'h0);
         DataIn   = 8'h10;
         IN_VALID = 1'b1;
         @(posedge CLK); #1;
      end
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      wait_drain();
      for (int i = 0; i < 3; i++) begin
         check("bp_no_stray", 32'(OUT_VALID), 32'h0);
         @(posedge CLK); #1;
      end

      // Asynchronous reset in the third shift cycle aborts the word.
      send(8'hC0, 8'hC0, 1'b0, 1'b0, 1'b0);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      #2;
      RESET_N = 1'b0;
      #1;
      check("abort_dataout", 32'(DataOut), 32'h00);
      check("abort_ovf", 32'(OVF), 32'h0);
      check("abort_out_valid", 32'(OUT_VALID), 32'h0);
      check("abort_busy", 32'(BUSY), 32'h0);
      @(negedge CLK);
      RESET_N = 1'b1;
      @(posedge CLK); #1;
      check("abort_in_ready", 32'(IN_READY), 32'h1);
      send(8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0);
      wait_drain();

      // Back-to-back stream with IN_VALID held high.
      send(8'h01, 8'h01, 1'b0, 1'b1, 1'b1);
      send(8'hF0, 8'h90, 1'b0, 1'b1, 1'b1);
      send(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
      wait_drain();

      for (int i = 0; i < 20; i++) begin
         x = 8'($urandom_range(0, 255));
         e = model(x);
         send(x, e.dout, e.ovf, 1'b1, 1'b0);
      end
      wait_drain();

      check("sb_empty", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
